// File: rtl/sram_port_ctrl.sv
// Front-end controller for a single-port RW0-style SRAM macro: zero-fills the
// array after reset, arbitrates write/read requests and returns held read data.
module sram_port_ctrl #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 76,
  parameter int MASK_W        = 4,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [MASK_W-1:0] w_mask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              rresp_valid,
  output logic [DATA_W-1:0] rresp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam state_t            RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              w_fire_s;
  logic              r_fire_s;

  // Writes win the single port; a read only fires when no write is offered.
  assign w_ready  = (state_q == ST_IDLE);
  assign r_ready  = (state_q == ST_IDLE) && !w_valid;
  assign w_fire_s = w_valid && w_ready;
  assign r_fire_s = r_valid && r_ready;

  // Macro port drive: fill writes during INIT, otherwise the winning request.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wmask = {MASK_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    case (state_q)
      ST_INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt_q;
        sram_wmask = {MASK_W{1'b1}};
      end
      ST_IDLE: begin
        if (w_fire_s) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = w_addr;
          sram_wmask = w_mask;
          sram_wdata = w_data;
        end else if (r_fire_s) begin
          sram_en    = 1'b1;
          sram_addr  = r_addr;
        end else begin
          sram_en    = 1'b0;
        end
      end
      default: begin
        sram_en    = 1'b0;
      end
    endcase
  end

  // Next-state: fill counter walks the whole array once, then IDLE forever.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = RESET_STATE;
        init_cnt_d = {ADDR_W{1'b0}};
      end
    endcase
  end

  // The macro returns data one cycle after the read enable; capture it then.
  always_comb begin
    rd_pend_d = r_fire_s;
    if (rd_pend_q) begin
      hold_d = sram_rdata;
    end else begin
      hold_d = hold_q;
    end
  end

  assign rresp_valid = rd_pend_q;
  assign rresp_data  = rd_pend_q ? sram_rdata : hold_q;

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= {ADDR_W{1'b0}};
      rd_pend_q  <= 1'b0;
      hold_q     <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_pend_q  <= rd_pend_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Front-end controller for one single-port synchronous SRAM macro (RW0-style: 1-cycle registered read, per-segment write mask).
- Arbitrates a write request channel and a read request channel onto the single port.
- Zero-fills the whole array after reset.
- Returns read data with a valid pulse and holds it stable until the next read response.
- Sits between cache/TLB array logic (upstream) and the *_ext macro (downstream).

Parameters:
- ADDR_W, 9, address width; array depth = 2^ADDR_W.
- DATA_W, 76, data word width.
- MASK_W, 4, write-mask segments; DATA_W must be divisible by MASK_W; segment width = DATA_W/MASK_W.
- INIT_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = go straight to IDLE.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- w_valid  in  1  write request.
- w_ready  out  1  write accepted when w_valid & w_ready.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- w_mask  in  MASK_W  per-segment write enable.
- r_valid  in  1  read request.
- r_ready  out  1  read accepted when r_valid & r_ready.
- r_addr  in  ADDR_W  read address.
- rresp_valid  out  1  one-cycle pulse: read data available.
- rresp_data  out  DATA_W  read data; held stable between pulses.
- sram_addr  out  ADDR_W  to macro RW0_addr.
- sram_en  out  1  to macro RW0_en.
- sram_wmode  out  1  to macro RW0_wmode (1 = write).
- sram_wmask  out  MASK_W  to macro RW0_wmask.
- sram_wdata  out  DATA_W  to macro RW0_wdata.
- sram_rdata  in  DATA_W  from macro RW0_rdata; valid the cycle after a read enable.

Behaviour:
- States: INIT, IDLE. Async reset forces:
  - state = INIT if INIT_ON_RESET=1, else IDLE.
  - init_cnt = 0, rresp_valid = 0, hold register = 0, read-pending flag = 0.
- INIT:
  - w_ready = 0, r_ready = 0.
  - Each cycle drive sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0, sram_addr=init_cnt, then increment init_cnt.
  - After the cycle writing address 2^ADDR_W-1, move to IDLE. INIT lasts exactly 2^ADDR_W cycles.
  - Requests presented during INIT are not accepted and are not lost: the source holds them.
- IDLE:
  - w_ready = 1. r_ready = !w_valid (write has priority; the single port cannot serve both).
  - Write fire: sram_en=1, sram_wmode=1, sram_addr=w_addr, sram_wmask=w_mask, sram_wdata=w_data. w_mask=0 still fires and changes no bits.
  - Read fire: sram_en=1, sram_wmode=0, sram_addr=r_addr, sram_wmask=0, sram_wdata=0.
  - No fire: sram_en=0, sram_wmode=0, sram_addr=0.
  - All sram_* outputs are combinational from state and requests.
- Read response:
  - Read-pending flag registers "read fired".
  - Cycle N+1 after a read fire at cycle N: rresp_valid=1 and rresp_data=sram_rdata; the hold register captures sram_rdata.
  - Otherwise rresp_valid=0 and rresp_data=hold register. Later writes to the same address do not change rresp_data until the next response.
- Back-to-back reads: one per cycle, throughput 1. Responses come in order with fixed latency 1.
- Read-after-write to the same address in consecutive cycles returns the new data, because the macro write completes before the next read.
- Reset asserted mid-INIT restarts the fill from address 0. Reset asserted mid-read drops the pending response: no rresp_valid after reset.
- No internal buffering: the upstream block must consume rresp at the pulse, or rely on the hold register.

Test Plan:
- Reset, ADDR_W=4, INIT_ON_RESET=1:
  - Exactly 16 cycles with sram_en=1, sram_wmode=1, addr 0..15, wmask=4'hF, wdata=0; w_ready=r_ready=0 throughout.
  - IDLE on cycle 17; a read of addr 7 returns 0.
- Write addr 5 data 76'h123456789ABCDEF012 mask 4'hF, then read addr 5 next cycle -> rresp_valid pulses one cycle after the read fire with the same data.
- Write addr 5 data all-ones, mask 4'b0101 (segment width 19) -> subsequent read returns segments 0 and 2 all-ones and segments 1 and 3 zero.
- w_valid=r_valid=1 in the same cycle (w_addr=3, r_addr=3) -> write fires, r_ready=0. Read fires the next cycle and returns the newly written data.
- Read addr 2 (value A), then write addr 2 value B with no further reads -> rresp_data stays A for 10 cycles; rresp_valid pulsed only once.
- Assert reset at init_cnt=9 -> outputs cleared immediately (asynchronous). Fill restarts at addr 0 after release; a read fired just before reset produces no rresp_valid.
